fifo_stream_buffer: RTL and testbench

Elastic FWFT word buffer placed between the round-robin channel arbiter output and the SRAM FIFO input in the BUS_CLK domain. It absorbs SRAM write stalls so the ADC receiver FIFOs keep draining, and reports occupancy, high-watermark and near-full status. Both the upstream and downstream interfaces are empty/data/pop style, matching the arbiter-to-SRAM-FIFO link.

---
 rtl/fifo_stream_buffer_pkg.sv | 18 +
 rtl/fifo_stream_buffer_mem.sv | 33 +++
 rtl/fifo_stream_buffer.sv | 153 +++++++++++++++
 tb/tb_fifo_stream_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_buffer_pkg.sv
// Shared constants and elaboration helpers for the fifo_stream_buffer block.
//   WORD_W : data word width carried through the buffer
//   clog2  : ceiling log2, used to cross-check pointer width against depth
package fifo_stream_buffer_pkg;

   localparam int unsigned WORD_W = 32;

   // Smallest r such that 2**r >= v (v >= 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = 32'(i + 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_stream_buffer_mem.sv
// DEPTH x WORD_W simple dual-port storage: synchronous write, asynchronous read.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
// Contents are intentionally not reset.
module fifo_stream_buffer_mem
   import fifo_stream_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read port
   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_stream_buffer.sv
// Elastic first-word-fall-through buffer between the channel arbiter and the
// SRAM FIFO. Absorbs downstream stalls and reports occupancy status.
//   BUS_CLK, BUS_RST          : clock, asynchronous active-high reset
//   IN_EMPTY, IN_DATA, IN_READ: upstream FWFT pop interface
//   OUT_EMPTY, OUT_DATA, OUT_READ: downstream FWFT pop interface
//   FLUSH                     : synchronous clear of the contents
//   COUNT, NEAR_FULL, FULL    : registered occupancy status
// Optional build macro FIFO_STREAM_BUFFER_STATS_EN adds WORD_CNT, MAX_COUNT
// and STALL_CNT statistics outputs.
module fifo_stream_buffer
   import fifo_stream_buffer_pkg::*;
#(
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned AW            = 4,
   parameter int unsigned NEAR_FULL_LVL = 12
) (
   input  logic              BUS_CLK,
   input  logic              BUS_RST,
   input  logic              IN_EMPTY,
   input  logic [WORD_W-1:0] IN_DATA,
   output logic              IN_READ,
   output logic              OUT_EMPTY,
   output logic [WORD_W-1:0] OUT_DATA,
   input  logic              OUT_READ,
   input  logic              FLUSH,
   output logic [AW:0]       COUNT,
   output logic              NEAR_FULL,
`ifdef FIFO_STREAM_BUFFER_STATS_EN
   output logic [31:0]       WORD_CNT,
   output logic [AW:0]       MAX_COUNT,
   output logic [15:0]       STALL_CNT,
`endif
   output logic              FULL
);

   localparam int unsigned CW = AW + 1;

   // Elaboration-time parameter sanity checks
   if (AW != clog2(DEPTH) || DEPTH < 4 || DEPTH > 256 || (32'd1 << AW) != DEPTH) begin : g_bad_depth
      $error("fifo_stream_buffer: DEPTH must be a power of two in 4..256 and AW == log2(DEPTH)");
   end
   if (NEAR_FULL_LVL >= DEPTH) begin : g_bad_lvl
      $error("fifo_stream_buffer: NEAR_FULL_LVL must be below DEPTH");
   end

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              near_full_q, near_full_d;
   logic              push_c, pop_c;
   logic [WORD_W-1:0] rd_data_c;

   // Upstream pop uses only registered FULL, so OUT_READ never reaches IN_READ.
   assign push_c  = !IN_EMPTY && !full_q && !FLUSH && !BUS_RST;
   assign pop_c   = OUT_READ && !empty_q && !FLUSH;
   assign IN_READ = push_c;

   fifo_stream_buffer_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (BUS_CLK),
      .we    (push_c),
      .waddr (wr_ptr_q),
      .wdata (IN_DATA),
      .raddr (rd_ptr_q),
      .rdata (rd_data_c)
   );

   // Pointer, occupancy and flag next-state; FLUSH overrides push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (FLUSH) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
      empty_d     = (count_d == '0);
      full_d      = (count_d == CW'(DEPTH));
      near_full_d = (count_d >= CW'(NEAR_FULL_LVL));
   end

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         near_full_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         near_full_q <= near_full_d;
      end
   end

   // Head word is masked while empty so stale/unreset memory never shows.
   assign OUT_DATA  = empty_q ? '0 : rd_data_c;
   assign OUT_EMPTY = empty_q;
   assign COUNT     = count_q;
   assign FULL      = full_q;
   assign NEAR_FULL = near_full_q;

`ifdef FIFO_STREAM_BUFFER_STATS_EN
   logic [31:0] word_cnt_q, word_cnt_d;
   logic [AW:0] max_count_q, max_count_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Statistics: pop total, occupancy high-watermark, saturating stall cycles.
   always_comb begin
      word_cnt_d  = word_cnt_q;
      max_count_d = max_count_q;
      stall_cnt_d = stall_cnt_q;
      if (FLUSH) begin
         word_cnt_d  = '0;
         max_count_d = '0;
      end else begin
         if (pop_c) word_cnt_d = word_cnt_q + 32'd1;
         if (count_d > max_count_q) max_count_d = count_d;
      end
      if (!IN_EMPTY && full_q && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         word_cnt_q  <= '0;
         max_count_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         max_count_q <= max_count_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign WORD_CNT  = word_cnt_q;
   assign MAX_COUNT = max_count_q;
   assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_buffer.sv
// Directed self-checking bench for fifo_stream_buffer (DEPTH=16, NEAR_FULL_LVL=12).
module tb_fifo_stream_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_empty;
   logic [31:0] in_data;
   logic        in_read;
   logic        out_empty;
   logic [31:0] out_data;
   logic        out_read;
   logic        flush;
   logic [4:0]  count;
   logic        near_full;
   logic        full;
`ifdef FIFO_STREAM_BUFFER_STATS_EN
   logic [31:0] word_cnt;
   logic [4:0]  max_count;
   logic [15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fifo_stream_buffer #(
      .DEPTH         (16),
      .AW            (4),
      .NEAR_FULL_LVL (12)
   ) dut (
      .BUS_CLK   (clk),
      .BUS_RST   (rst),
      .IN_EMPTY  (in_empty),
      .IN_DATA   (in_data),
      .IN_READ   (in_read),
      .OUT_EMPTY (out_empty),
      .OUT_DATA  (out_data),
      .OUT_READ  (out_read),
      .FLUSH     (flush),
      .COUNT     (count),
      .NEAR_FULL (near_full),
`ifdef FIFO_STREAM_BUFFER_STATS_EN
      .WORD_CNT  (word_cnt),
      .MAX_COUNT (max_count),
      .STALL_CNT (stall_cnt),
`endif
      .FULL      (full)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_empty = 1'b1; in_data = '0; out_read = 1'b0; flush = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic push_words(input int n, input logic [31:0] base);
      out_read = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_empty = 1'b0; in_data = base + 32'(i);
         cycle();
      end
      in_empty = 1'b1;
      #1;
   endtask

   task automatic pop_words(input int n);
      in_empty = 1'b1; out_read = 1'b1;
      for (int i = 0; i < n; i++) cycle();
      out_read = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_empty = 1'b0; in_data = 32'h1234_5678; out_read = 1'b1; flush = 1'b0;
      cycle();
      n_checks++; if (count !== 5'd0)   begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL reset_out_empty got %b exp 1", out_empty); end
      n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
      n_checks++; if (near_full !== 1'b0) begin n_fail++; $display("FAIL reset_near_full got %b exp 0", near_full); end
      n_checks++; if (in_read !== 1'b0) begin n_fail++; $display("FAIL reset_in_read got %b exp 0", in_read); end
      n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      do_reset();
   endtask

   task automatic test_single_word();
      in_empty = 1'b0; in_data = 32'hA5A5_0001; out_read = 1'b0;
      #1;
      n_checks++; if (in_read !== 1'b1) begin n_fail++; $display("FAIL single_in_read got %b exp 1", in_read); end
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_before got %b exp 1", out_empty); end
      cycle();
      in_empty = 1'b1;
      #1;
      n_checks++; if (out_empty !== 1'b0) begin n_fail++; $display("FAIL single_out_empty got %b exp 0", out_empty); end
      n_checks++; if (out_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_out_data got %h exp a5a50001", out_data); end
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
      pop_words(1);
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_drained got %b exp 1", out_empty); end
   endtask

   // Fill with upstream always valid for 20 cycles; leaves words C0DE_0000+0..15 inside.
   task automatic test_fill(output int src);
      int acc;
      int reads;
      logic exp_rd;
      acc = 0; reads = 0; src = 0;
      out_read = 1'b0;
      for (int i = 0; i < 20; i++) begin
         in_empty = 1'b0; in_data = 32'hC0DE_0000 + 32'(src);
         #1;
         exp_rd = (acc < 16);
         n_checks++; if (in_read !== exp_rd) begin n_fail++; $display("FAIL fill_in_read cyc %0d got %b exp %b", i, in_read, exp_rd); end
         if (in_read) begin src++; reads++; end
         if (exp_rd) acc++;
         cycle();
         n_checks++; if (count !== 5'(acc)) begin n_fail++; $display("FAIL fill_count cyc %0d got %0d exp %0d", i, count, acc); end
         n_checks++; if (near_full !== (acc >= 12)) begin n_fail++; $display("FAIL fill_near_full cyc %0d got %b exp %b", i, near_full, acc >= 12); end
         n_checks++; if (full !== (acc == 16)) begin n_fail++; $display("FAIL fill_full cyc %0d got %b exp %b", i, full, acc == 16); end
      end
      n_checks++; if (reads !== 16) begin n_fail++; $display("FAIL fill_read_cycles got %0d exp 16", reads); end
   endtask

   // From FULL, pop continuously while upstream streams words 16..99.
   task automatic test_back_to_back(input int src_in);
      int src;
      int exp;
      src = src_in; exp = 0;
      out_read = 1'b1;
      for (int cyc = 0; cyc < 300 && exp < 100; cyc++) begin
         in_empty = (src >= 100);
         in_data  = (src < 100) ? 32'hC0DE_0000 + 32'(src) : 32'h0;
         #1;
         n_checks++; if (out_empty !== 1'b0) begin n_fail++; $display("FAIL stream_gap cyc %0d got empty %b exp 0", cyc, out_empty); end
         n_checks++; if (out_data !== 32'hC0DE_0000 + 32'(exp)) begin n_fail++; $display("FAIL stream_data got %h exp %h", out_data, 32'hC0DE_0000 + 32'(exp)); end
         if (src < 100) begin
            n_checks++; if (count !== 5'd15 && count !== 5'd16) begin n_fail++; $display("FAIL stream_count got %0d exp 15/16", count); end
         end
         if (in_read) src++;
         exp++;
         cycle();
      end
      out_read = 1'b0; in_empty = 1'b1;
      #1;
      n_checks++; if (exp !== 100) begin n_fail++; $display("FAIL stream_total got %0d exp 100", exp); end
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL stream_final_empty got %b exp 1", out_empty); end
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL stream_final_count got %0d exp 0", count); end
   endtask

   task automatic test_flush();
      do_reset();
      push_words(7, 32'h0000_0070);
      n_checks++; if (count !== 5'd7) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 7", count); end
      flush = 1'b1; out_read = 1'b1; in_empty = 1'b0; in_data = 32'h0000_0BAD;
      #1;
      n_checks++; if (in_read !== 1'b0) begin n_fail++; $display("FAIL flush_in_read got %b exp 0", in_read); end
      cycle();
      flush = 1'b0; out_read = 1'b0; in_data = 32'h0000_600D;
      #1;
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", out_empty); end
      n_checks++; if (in_read !== 1'b1) begin n_fail++; $display("FAIL flush_resume_read got %b exp 1", in_read); end
      cycle();
      in_empty = 1'b1;
      #1;
      n_checks++; if (out_data !== 32'h0000_600D) begin n_fail++; $display("FAIL flush_next_word got %h exp 0000600d", out_data); end
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL flush_next_count got %0d exp 1", count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      push_words(5, 32'h0000_0050);
      in_empty = 1'b0; in_data = 32'h0000_0055;
      #1;
      n_checks++; if (in_read !== 1'b1) begin n_fail++; $display("FAIL arst_pre_read got %b exp 1", in_read); end
      n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL arst_pre_count got %0d exp 5", count); end
      rst = 1'b1;
      #1;
      n_checks++; if (in_read !== 1'b0) begin n_fail++; $display("FAIL arst_in_read got %b exp 0", in_read); end
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL arst_out_empty got %b exp 1", out_empty); end
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", count); end
      cycle();
      rst = 1'b0;
      #1;
      n_checks++; if (in_read !== 1'b1) begin n_fail++; $display("FAIL arst_resume_read got %b exp 1", in_read); end
      cycle();
      in_empty = 1'b1;
      #1;
      n_checks++; if (out_data !== 32'h0000_0055) begin n_fail++; $display("FAIL arst_head_word got %h exp 00000055", out_data); end
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL arst_count_after got %0d exp 1", count); end
      pop_words(1);
      n_checks++; if (out_empty !== 1'b1) begin n_fail++; $display("FAIL arst_no_dup got %b exp 1", out_empty); end
   endtask

`ifdef FIFO_STREAM_BUFFER_STATS_EN
   task automatic test_stats();
      do_reset();
      push_words(19, 32'h5000_0000);
      pop_words(16);
      push_words(16, 32'h6000_0000);
      pop_words(16);
      push_words(8, 32'h7000_0000);
      pop_words(8);
      n_checks++; if (word_cnt !== 32'd40) begin n_fail++; $display("FAIL stats_word_cnt got %0d exp 40", word_cnt); end
      n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL stats_stall_cnt got %0d exp 3", stall_cnt); end
      n_checks++; if (max_count !== 5'd16) begin n_fail++; $display("FAIL stats_max_count got %0d exp 16", max_count); end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      #1;
      n_checks++; if (word_cnt !== 32'd0) begin n_fail++; $display("FAIL stats_flush_word_cnt got %0d exp 0", word_cnt); end
      n_checks++; if (max_count !== 5'd0) begin n_fail++; $display("FAIL stats_flush_max got %0d exp 0", max_count); end
   endtask
`endif

   initial begin
      int src;
      test_reset();
      test_single_word();
      do_reset();
      test_fill(src);
      test_back_to_back(src);
      test_flush();
      test_async_reset();
`ifdef FIFO_STREAM_BUFFER_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
